// File: rtl/spi_master.sv
// spi_master: command-side SPI master. It drives an SPI slave + RAM wrapper in the
// single system clock domain, with clk also serving as SCK.
//
// It takes one command per valid/ready handshake and serialises the command into a
// slave frame. For read-data commands it captures the byte returned on MISO and
// presents that byte on a one-cycle response strobe.
//
// Ports:
//   clk       - system clock; all logic runs on posedge
//   rst_n     - asynchronous active-low reset
//   cmd_valid - command request
//   cmd_ready - master idle and able to accept a command
//   cmd_type  - 00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   cmd_data  - address or data payload
//   rd_valid  - one-cycle strobe: rd_data holds a fresh byte
//   rd_data   - last byte captured from MISO; held until the next capture
//   busy      - high from accept until the end of the inter-frame gap
//   SS_n      - slave select, active low
//   MOSI      - serial data to the slave
//   MISO      - serial data from the slave
module spi_master #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned GAP    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StSel, StShift, StWait, StCapture, StGap
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  frame_q, frame_d;
    logic [7:0]  rd_shift_q, rd_shift_d;
    logic [3:0]  bit_idx;

    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_q     <= '0;
            rd_shift_q  <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            rd_shift_q  <= rd_shift_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Next-state logic. The single counter is reused by SHIFT, WAIT, CAPTURE and GAP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        rd_shift_d = rd_shift_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    frame_d = {cmd_type, cmd_data};
                    state_d = StStart;
                end
            end
            StStart: state_d = StSel;
            StSel: begin
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (cnt_q == 4'd9) begin
                    cnt_d   = '0;
                    state_d = (frame_q[9:8] == 2'b11) ? StWait : StGap;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWait: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCapture: begin
                rd_shift_d = {rd_shift_q[6:0], MISO};
                if (cnt_q == 4'd7) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the upcoming state, so that every output is a flop.
    always_comb begin
        bit_idx     = 4'd9 - cnt_d;
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        ss_n_d      = (state_d == StIdle) || (state_d == StGap);
        mosi_d      = 1'b0;
        if (state_d == StSel) begin
            mosi_d = frame_d[9];
        end else if (state_d == StShift) begin
            mosi_d = frame_d[bit_idx];
        end
        // Leaving CAPTURE means the eighth sample is being taken on this edge.
        rd_valid_d = (state_q == StCapture) && (state_d == StGap);
        rd_data_d  = rd_valid_d ? rd_shift_d : rd_data_q;
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master, built with RD_LAT=3 and GAP=2.
module tb_spi_master;

    localparam int unsigned RD_LAT = 3;
    localparam int unsigned GAP    = 2;
    localparam int          LEN    = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-cycle records of one frame, index k = cycle T+k.
    logic       ss_rec   [0:LEN];
    logic       mo_rec   [0:LEN];
    logic       rv_rec   [0:LEN];
    logic       rdy_rec  [0:LEN];
    logic       busy_rec [0:LEN];
    logic [7:0] rdd_rec  [0:LEN];

    // Behavioural model of the slave + RAM wrapper, fed from decoded MOSI frames.
    logic [7:0] ram_m [0:255];
    logic [7:0] ram_addr = 8'h00;
    logic [9:0] exp_q [$];

    spi_master #(
        .RD_LAT (RD_LAT),
        .GAP    (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command and return right after the accepting posedge (edge T).
    task automatic accept(input logic [1:0] typ, input logic [7:0] dat);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = typ;
        cmd_data  = dat;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
    endtask

    // Run one frame, recording cycles T+1..T+LEN and driving MISO with mbyte
    // (MSB first) during cycles T+mstart..T+mstart+7, zero elsewhere.
    task automatic run_frame(input logic [1:0] typ, input logic [7:0] dat,
                             input logic [7:0] mbyte, input int mstart);
        logic [7:0] msh;
        logic [9:0] rf;
        msh = mbyte;
        rf  = '0;
        accept(typ, dat);
        for (int k = 1; k <= LEN; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Changes after accept must not reach the current frame.
                cmd_valid = 1'b0;
                cmd_type  = ~typ;
                cmd_data  = ~dat;
            end
            ss_rec[k]   = SS_n;
            mo_rec[k]   = MOSI;
            rv_rec[k]   = rd_valid;
            rdy_rec[k]  = cmd_ready;
            busy_rec[k] = busy;
            rdd_rec[k]  = rd_data;
            if (k >= mstart && k < mstart + 8) begin
                MISO = msh[7];
                msh  = {msh[6:0], 1'b0};
            end else begin
                MISO = 1'b0;
            end
        end
        for (int k = 3; k <= 12; k++) rf = {rf[8:0], mo_rec[k]};
        case (rf[9:8])
            2'b00, 2'b10: ram_addr = rf[7:0];
            2'b01:        ram_m[ram_addr] = rf[7:0];
            default:      ;
        endcase
    endtask

    task automatic check_frame(input string tag, input logic [9:0] f, input bit rd,
                               input logic [7:0] rdb);
        int         low, last_low, bad_mosi, rv_cnt, rv_k, rdy_k, rdy_exp;
        logic [10:0] mw;
        low = 0; last_low = 0; bad_mosi = 0; rv_cnt = 0; rv_k = 0; rdy_k = 0;
        mw  = '0;
        rdy_exp = rd ? 26 : 15;
        for (int k = 1; k <= LEN; k++) begin
            if (!ss_rec[k]) begin
                low++;
                last_low = k;
            end else if (mo_rec[k]) begin
                bad_mosi++;
            end
            if (rv_rec[k]) begin
                rv_cnt++;
                rv_k = k;
            end
            if (rdy_rec[k] && rdy_k == 0) rdy_k = k;
        end
        for (int k = 2; k <= 12; k++) mw = {mw[9:0], mo_rec[k]};
        check({tag, "_ss_first"}, 32'(ss_rec[1]), 32'd0);
        check({tag, "_ready_t1"}, 32'(rdy_rec[1]), 32'd0);
        check({tag, "_low_cnt"}, low, rd ? 23 : 12);
        check({tag, "_last_low"}, last_low, rd ? 23 : 12);
        check({tag, "_mosi"}, 32'(mw), 32'({f[9], f}));
        check({tag, "_idle_mosi"}, bad_mosi, 0);
        check({tag, "_rv_cnt"}, rv_cnt, rd ? 1 : 0);
        check({tag, "_ready_k"}, rdy_k, rdy_exp);
        check({tag, "_busy"}, 32'({busy_rec[rdy_exp-1], busy_rec[rdy_exp]}), 32'b10);
        if (rd) begin
            check({tag, "_rv_k"}, rv_k, 24);
            check({tag, "_rd_data"}, 32'(rdd_rec[24]), 32'(rdb));
            check({tag, "_rd_hold"}, 32'(rdd_rec[LEN]), 32'(rdb));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc, rx, hi_run, n, last_acc;
        bit   took;
        logic prev_ss;
        logic [10:0] sh;

        for (int i = 0; i < 256; i++) ram_m[i] = 8'h00;

        // Reset values.
        #2 rst_n = 1'b0;
        #1;
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rv", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write-addr 5, write-data 0x25, read-addr 5, read-data.
        run_frame(2'b00, 8'h05, 8'h00, 100);
        check_frame("wa05", 10'h005, 1'b0, 8'h00);
        run_frame(2'b01, 8'h25, 8'h00, 100);
        check_frame("wd25", 10'h125, 1'b0, 8'h00);
        check("ram5", 32'(ram_m[5]), 32'h25);
        run_frame(2'b10, 8'h05, 8'h00, 100);
        check_frame("ra05", 10'h205, 1'b0, 8'h00);
        run_frame(2'b11, 8'h3C, ram_m[ram_addr], 16);
        check_frame("rd25", 10'h33C, 1'b1, 8'h25);

        // MISO window: aligned at T+16, then one cycle early.
        run_frame(2'b11, 8'h00, 8'hA5, 16);
        check_frame("rdA5", 10'h300, 1'b1, 8'hA5);
        run_frame(2'b11, 8'h00, 8'hA5, 15);
        check_frame("rd_early", 10'h300, 1'b1, 8'h4A);

        // cmd_valid held high with alternating write-addr / write-data.
        acc = 0; rx = 0; hi_run = 0; n = 0; last_acc = 0;
        prev_ss = 1'b1;
        sh = '0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = 2'b00;
        cmd_data  = 8'h40;
        while (rx < 4 && n < 200) begin
            took = 1'b0;
            if (!SS_n) begin
                sh = {sh[9:0], MOSI};
                if (prev_ss && rx >= 1) check("b2b_gap", hi_run, 3);
                hi_run = 0;
            end else begin
                hi_run++;
                if (!prev_ss) begin
                    rx++;
                    check("b2b_frame", 32'(sh[9:0]), 32'(exp_q.pop_front()));
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({cmd_type, cmd_data});
                if (acc >= 1) check("b2b_spacing", n - last_acc, 15);
                last_acc = n;
                acc++;
                took = 1'b1;
            end
            prev_ss = SS_n;
            @(negedge clk);
            n++;
            if (took) begin
                if (acc < 4) begin
                    cmd_type = {1'b0, acc[0]};
                    cmd_data = 8'h40 + 8'(acc);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", acc, 4);
        check("b2b_frames", rx, 4);
        check("b2b_leftover", exp_q.size(), 0);

        // Reset during SHIFT bit 5 of a read-data frame.
        accept(2'b11, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        check("mid_ss_low", 32'(SS_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n", 32'(SS_n), 32'd1);
        check("mid_rst_mosi", 32'(MOSI), 32'd0);
        check("mid_rst_rv", 32'(rd_valid), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_ss_n", 32'(SS_n), 32'd1);
        run_frame(2'b00, 8'h0A, 8'h00, 100);
        check_frame("wa0A", 10'h00A, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Command-side SPI master that drives the existing SPI slave + RAM wrapper over SS_n/MOSI/MISO, all in the single system clock domain (clk serves as SCK).
- Accepts one memory command per valid/ready handshake and serialises it into a slave frame.
- For read-data commands, captures the 8-bit byte the slave returns on MISO and presents it on a one-cycle response strobe.

Parameters:
- RD_LAT, 2: clk cycles between the last command bit and the first MISO data bit on read-data frames (range 1..15).
- GAP, 1: minimum clk cycles SS_n stays high between frames (range 1..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master idle and able to accept a command.
- cmd_type  input  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  input  8  address or data payload; ignored for 11.
- rd_valid  output  1  one-cycle strobe: rd_data valid.
- rd_data  output  8  byte captured from MISO; held until the next capture.
- busy  output  1  high from accept until the end of the gap.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to the slave.
- MISO  input  1  serial data from the slave.

Behaviour:
- Reset values (asynchronous):
  - SS_n=1, MOSI=0, cmd_ready=1, busy=0, rd_valid=0, rd_data=0x00.
  - FSM returns to IDLE.
  - All counters and shift registers are cleared.
- Accept: on a posedge with cmd_valid && cmd_ready, latch frame = {cmd_type, cmd_data}, a 10-bit value. Call this edge T.
  - cmd_ready drops at T+1 and busy rises at T+1.
  - Commands presented while cmd_ready=0 are not consumed.
- FSM states: IDLE, START, SEL, SHIFT, WAIT, CAPTURE, GAP. All outputs are registered. Cycle offsets are counted from T.
  - START (T+1): SS_n=0, MOSI=0.
  - SEL (T+2): MOSI=frame[9]. This is the slave's write/read select bit.
  - SHIFT (T+3..T+12): MOSI=frame[9-k] for k=0..9, MSB first. A 4-bit counter ends the state at k=9.
  - After SHIFT, types 00/01/10 go to GAP. SS_n=1 at T+13.
  - Type 11 goes to WAIT: MOSI=0 and SS_n=0 for RD_LAT cycles (T+13..T+12+RD_LAT).
  - CAPTURE: 8 cycles. On each posedge MISO is shifted into rd_shift MSB first; the first sample is taken at the edge ending cycle T+13+RD_LAT.
  - After the 8th sample: rd_data <= rd_shift, rd_valid=1 for exactly one cycle, SS_n=1, then go to GAP.
  - GAP: SS_n=1 and MOSI=0 for GAP cycles, then IDLE with cmd_ready=1 and busy=0.
- Frame lengths:
  - Write/read-addr: SS_n low 12 cycles. Next accept is earliest at T+13+GAP.
  - Read-data: SS_n low 12+RD_LAT+8 cycles.
- MOSI is 0 whenever SS_n=1.
- rd_valid is never asserted for types 00/01/10.
- No command queueing; cmd_data and cmd_type changes after accept have no effect on the current frame.
- MISO is ignored outside CAPTURE.
- Reset mid-frame:
  - SS_n goes high immediately (asynchronously).
  - rd_valid stays 0 and any partial rd_shift is discarded.
  - After release, the master is IDLE with cmd_ready=1 on the first clk edge.
- Simultaneous rd_valid pulse and a new cmd_valid: the command is not accepted until cmd_ready returns after GAP.

Test Plan:
- Accept write-addr 0x05 → SS_n low exactly 12 cycles; MOSI over T+2..T+12 = 0, 0,0,0,0,0,0,0,1,0,1; then SS_n=1 and cmd_ready=1 at T+13+GAP.
- Accept write-data 0x25 after write-addr 0x05, using the slave+RAM wrapper as DUT load → RAM location 5 holds 0x25; rd_valid never pulses.
- Sequence read-addr 0x05, then read-data, against the wrapper with RAM[5]=0x25 → rd_valid pulses once with rd_data=0x25; SS_n rises the same cycle; rd_data holds 0x25 afterwards.
- Bit-accurate MISO model with RD_LAT=3 driving 0xA5 MSB first from T+16 → rd_data=0xA5. With the model shifted one cycle early → rd_data≠0xA5, confirming the latency window.
- Hold cmd_valid high continuously with alternating 00/01 commands → each accepted only when cmd_ready=1; SS_n high for ≥GAP cycles between frames; no command dropped or duplicated.
- Assert rst_n=0 during SHIFT bit 5 of a read-data frame → SS_n=1 and MOSI=0 immediately, rd_valid=0. After release, a new write-addr 0x0A frame is transmitted correctly.
